// File: rtl/cpu_ctrl_fsm_p_pkg.sv
// Shared types for the multi-cycle controller: opcodes, branch conditions, FSM states, ALU ops.
// Bus-select offsets for IR/G/DIN sit just above the register range, so they depend on NREG.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_MV  = 3'd0,
    OP_MVT = 3'd1,
    OP_ADD = 3'd2,
    OP_SUB = 3'd3,
    OP_LD  = 3'd4,
    OP_ST  = 3'd5,
    OP_AND = 3'd6,
    OP_BRN = 3'd7
  } opcode_e;

  typedef enum logic [2:0] {
    C_AL = 3'd0,
    C_EQ = 3'd1,
    C_NE = 3'd2,
    C_CC = 3'd3,
    C_CS = 3'd4,
    C_PL = 3'd5,
    C_MI = 3'd6,
    C_LT = 3'd7
  } cond_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_F0   = 3'd1,
    S_F1   = 3'd2,
    S_T3   = 3'd3,
    S_T4   = 3'd4,
    S_MW   = 3'd5,
    S_T5   = 3'd6
  } state_e;

  localparam logic [1:0] ALU_ADDSUB = 2'b00;
  localparam logic [1:0] ALU_AND    = 2'b01;

  function automatic int sel_ir(input int nreg);
    return nreg;
  endfunction

  function automatic int sel_g(input int nreg);
    return nreg + 1;
  endfunction

  function automatic int sel_din(input int nreg);
    return nreg + 2;
  endfunction

endpackage

// File: rtl/cpu_ctrl_fsm_p_if.sv
// Controller <-> datapath bundle: decode inputs and memory handshake in, control strobes out.
// The master side is the controller; the slave side is the datapath/memory.
interface cpu_ctrl_fsm_p_if #(
  parameter int DATA_W = 16,
  parameter int NREG   = 8
);
  localparam int SEL_W = $clog2(NREG + 3);

  logic [DATA_W-1:0] ir;
  logic [3:0]        flags;
  logic              mem_ready;
  logic [SEL_W-1:0]  sel;
  logic [NREG-1:0]   reg_ld;
  logic              ir_ld;
  logic              a_ld;
  logic              g_ld;
  logic              flag_ld;
  logic              addr_ld;
  logic              dout_ld;
  logic              pc_incr;
  logic              add_sub;
  logic [1:0]        op;
  logic              mem_rd;
  logic              mem_wr;
  logic              done;

  modport master (
    input  ir, flags, mem_ready,
    output sel, reg_ld, ir_ld, a_ld, g_ld, flag_ld, addr_ld, dout_ld,
           pc_incr, add_sub, op, mem_rd, mem_wr, done
  );

  modport slave (
    output ir, flags, mem_ready,
    input  sel, reg_ld, ir_ld, a_ld, g_ld, flag_ld, addr_ld, dout_ld,
           pc_incr, add_sub, op, mem_rd, mem_wr, done
  );

endinterface

// File: rtl/cpu_ctrl_fsm_p_branch.sv
// Branch condition evaluator: cond field x {c,v,n,z} -> taken, purely combinational.
// Condition 7 is signed less-than, i.e. n xor v after a compare.
module cpu_branch_cond
  import cpu_ctrl_pkg::*;
(
  input  cond_e      cond,
  input  logic [3:0] flags,
  output logic       taken
);

  logic c, v, n, z;
  assign {c, v, n, z} = flags;

  always_comb begin
    taken = 1'b0;
    case (cond)
      C_AL: taken = 1'b1;
      C_EQ: taken = z;
      C_NE: taken = ~z;
      C_CC: taken = ~c;
      C_CS: taken = c;
      C_PL: taken = ~n;
      C_MI: taken = n;
      C_LT: taken = n ^ v;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/cpu_ctrl_fsm_p.sv
// Multi-cycle control FSM: 3..6 cycles per instruction with zero-wait memory, +1 per wait cycle.
// Memory strobes are held until mem_ready; run=0 only takes effect once the current instruction is done.
module cpu_ctrl_fsm_p #(
  parameter int DATA_W = 16,
  parameter int NREG   = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             run,
  cpu_ctrl_fsm_p_if.master bus
);
  import cpu_ctrl_pkg::*;

  localparam int REG_AW = $clog2(NREG);
  localparam int SEL_W  = $clog2(NREG + 3);

  localparam logic [SEL_W-1:0] SEL_PC  = SEL_W'(NREG - 1);
  localparam logic [SEL_W-1:0] SEL_IR  = SEL_W'(sel_ir(NREG));
  localparam logic [SEL_W-1:0] SEL_G   = SEL_W'(sel_g(NREG));
  localparam logic [SEL_W-1:0] SEL_DIN = SEL_W'(sel_din(NREG));
  localparam logic [NREG-1:0]  PC_OH   = {1'b1, {(NREG-1){1'b0}}};

  state_e            state, state_nx;
  opcode_e           opc;
  logic              imm;
  logic [REG_AW-1:0] rx, ry;
  logic [SEL_W-1:0]  operand;
  logic [NREG-1:0]   rx_oh;
  logic [1:0]        alu_op;
  logic              taken;
  logic              unused_ir;

  assign opc       = opcode_e'(bus.ir[DATA_W-1 -: 3]);
  assign imm       = bus.ir[DATA_W-4];
  assign rx        = bus.ir[DATA_W-5 -: REG_AW];
  assign ry        = bus.ir[REG_AW-1:0];
  assign operand   = imm ? SEL_IR : SEL_W'(ry);
  assign rx_oh     = NREG'(1) << rx;
  assign alu_op    = (opc == OP_AND) ? ALU_AND : ALU_ADDSUB;
  assign unused_ir = ^bus.ir;

  cpu_branch_cond u_cond (
    .cond  (cond_e'(rx[2:0])),
    .flags (bus.flags),
    .taken (taken)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    bus.sel     = '0;
    bus.reg_ld  = '0;
    bus.ir_ld   = 1'b0;
    bus.a_ld    = 1'b0;
    bus.g_ld    = 1'b0;
    bus.flag_ld = 1'b0;
    bus.addr_ld = 1'b0;
    bus.dout_ld = 1'b0;
    bus.pc_incr = 1'b0;
    bus.add_sub = 1'b0;
    bus.op      = ALU_ADDSUB;
    bus.mem_rd  = 1'b0;
    bus.mem_wr  = 1'b0;
    bus.done    = 1'b0;

    case (state)
      S_IDLE: if (run) state_nx = S_F0;

      S_F0: begin
        bus.sel     = SEL_PC;
        bus.addr_ld = 1'b1;
        bus.pc_incr = 1'b1;
        state_nx    = S_F1;
      end

      S_F1: begin
        bus.mem_rd = 1'b1;
        if (bus.mem_ready) begin
          bus.ir_ld = 1'b1;
          state_nx  = S_T3;
        end
      end

      S_T3: begin
        case (opc)
          OP_MV, OP_MVT: begin
            bus.sel    = (opc == OP_MVT) ? SEL_IR : operand;
            bus.reg_ld = rx_oh;
            bus.done   = 1'b1;
          end
          OP_ADD, OP_SUB, OP_AND: begin
            bus.sel  = SEL_W'(rx);
            bus.a_ld = 1'b1;
            state_nx = S_T4;
          end
          OP_LD, OP_ST: begin
            bus.sel     = SEL_W'(ry);
            bus.addr_ld = 1'b1;
            state_nx    = S_T4;
          end
          default: begin
            // BRN: stage PC into A; a not-taken branch retires here
            bus.sel  = SEL_PC;
            bus.a_ld = 1'b1;
            if (taken) state_nx = S_T4;
            else       bus.done = 1'b1;
          end
        endcase
      end

      S_T4: begin
        case (opc)
          OP_ADD, OP_SUB, OP_AND: begin
            bus.sel     = operand;
            bus.g_ld    = 1'b1;
            bus.flag_ld = 1'b1;
            bus.op      = alu_op;
            bus.add_sub = (opc == OP_SUB);
            state_nx    = S_T5;
          end
          OP_BRN: begin
            bus.sel  = SEL_IR;
            bus.g_ld = 1'b1;
            state_nx = S_T5;
          end
          OP_LD, OP_ST: state_nx = S_MW;
          default:      state_nx = S_T5;
        endcase
      end

      S_MW: begin
        // dout_ld is repeated each wait cycle so RX stays latched until the write lands
        if (opc == OP_ST) begin
          bus.sel     = SEL_W'(rx);
          bus.dout_ld = 1'b1;
          bus.mem_wr  = 1'b1;
          bus.done    = bus.mem_ready;
        end else begin
          bus.mem_rd = 1'b1;
          if (bus.mem_ready) state_nx = S_T5;
        end
      end

      S_T5: begin
        case (opc)
          OP_ADD, OP_SUB, OP_AND: begin
            bus.sel    = SEL_G;
            bus.reg_ld = rx_oh;
            bus.op     = alu_op;
          end
          OP_LD: begin
            bus.sel    = SEL_DIN;
            bus.reg_ld = rx_oh;
          end
          OP_BRN: begin
            bus.sel    = SEL_G;
            bus.reg_ld = PC_OH;
          end
          default: bus.sel = '0;
        endcase
        bus.done = 1'b1;
      end

      default: state_nx = S_IDLE;
    endcase

    if (bus.done) state_nx = run ? S_F0 : S_IDLE;
  end

endmodule

// File: tb/tb_cpu_ctrl_fsm_p.sv
// Bench for cpu_ctrl_fsm_p: directed vector table, hand sequences and random instructions
// checked against an instruction-level model (latency, write target, strobe counts).
module tb_cpu_ctrl_fsm_p;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst8_n, run8, rst16_n, run16;

  cpu_ctrl_fsm_p_if #(.DATA_W(16), .NREG(8))  bus8 ();
  cpu_ctrl_fsm_p_if #(.DATA_W(24), .NREG(16)) bus16 ();

  cpu_ctrl_fsm_p #(.DATA_W(16), .NREG(8)) dut8 (
    .clk(clk), .reset_n(rst8_n), .run(run8), .bus(bus8)
  );
  cpu_ctrl_fsm_p #(.DATA_W(24), .NREG(16)) dut16 (
    .clk(clk), .reset_n(rst16_n), .run(run16), .bus(bus16)
  );

  int n_pass = 0;
  int n_total = 0;

  typedef struct packed {
    logic [3:0] sel;
    logic [7:0] reg_ld;
    logic ir_ld, a_ld, g_ld, flag_ld, addr_ld, dout_ld, pc_incr, add_sub;
    logic [1:0] op;
    logic mem_rd, mem_wr, done;
  } obs_t;

  typedef struct {
    logic [15:0] ir;
    logic [3:0]  fl;
    int          fw, mw, cyc;
    logic [7:0]  rld;
    logic [3:0]  sel;
  } vec_t;

  obs_t tr[64];
  int   tr_len;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  function automatic obs_t snap();
    obs_t o;
    o.sel = bus8.sel; o.reg_ld = bus8.reg_ld; o.ir_ld = bus8.ir_ld; o.a_ld = bus8.a_ld;
    o.g_ld = bus8.g_ld; o.flag_ld = bus8.flag_ld; o.addr_ld = bus8.addr_ld;
    o.dout_ld = bus8.dout_ld; o.pc_incr = bus8.pc_incr; o.add_sub = bus8.add_sub;
    o.op = bus8.op; o.mem_rd = bus8.mem_rd; o.mem_wr = bus8.mem_wr; o.done = bus8.done;
    return o;
  endfunction

  // Called in the F0 cycle of an instruction, 1 time unit after the edge.
  // Memory answers after fw (fetch) or mw (LD/ST) wait cycles.
  task automatic run_instr(input logic [15:0] ir, input logic [3:0] fl, input int fw,
                           input int mw, input bit drop_run);
    int cnt = 0;
    bit fetched = 0;
    bit req;
    bit fin = 0;
    bus8.ir = ir; bus8.flags = fl; bus8.mem_ready = 1'b0;
    tr_len = 0;
    while (!fin && tr_len < 60) begin
      req = bus8.mem_rd | bus8.mem_wr;
      if (req) begin
        bus8.mem_ready = (cnt >= (fetched ? mw : fw));
        cnt++;
      end else bus8.mem_ready = 1'b0;
      if (drop_run && bus8.mem_wr) run8 = 1'b0;
      #1;
      tr[tr_len] = snap();
      if (bus8.ir_ld) fetched = 1;
      if (req && bus8.mem_ready) cnt = 0;
      fin = bus8.done;
      tr_len++;
      @(posedge clk); #1;
    end
    if (!fin) chk("instr_timeout", 32'd0, 32'd1);
  endtask

  // Instruction-level reference model
  function automatic bit m_taken(input int cond, input logic [3:0] f);
    case (cond)
      0: return 1'b1;
      1: return f[0];
      2: return !f[0];
      3: return !f[3];
      4: return f[3];
      5: return !f[1];
      6: return f[1];
      default: return f[1] ^ f[2];
    endcase
  endfunction

  function automatic int m_lat(input int opc, input bit tk);
    case (opc)
      0, 1:    return 3;
      2, 3, 6: return 5;
      4:       return 6;
      5:       return 5;
      default: return tk ? 5 : 3;
    endcase
  endfunction

  task automatic check_model(input logic [15:0] ir, input logic [3:0] fl, input int fw,
                             input int mw, input string tag);
    int opc = int'(ir[15:13]);
    bit imm = ir[12];
    int rx = int'(ir[11:9]);
    int ry = int'(ir[2:0]);
    bit tk = m_taken(rx, fl);
    bit alu = (opc == 2 || opc == 3 || opc == 6);
    bit mem = (opc == 4 || opc == 5);
    bit wr = (opc <= 4 || opc == 6 || (opc == 7 && tk));
    int e_sel, e_rld;
    int n_rd = 0, n_wr = 0, n_a = 0, n_g = 0, n_f = 0, n_rl = 0, n_bad = 0, n_dout = 0;
    case (opc)
      0:       e_sel = imm ? 8 : ry;
      1:       e_sel = 8;
      4:       e_sel = 10;
      5:       e_sel = rx;
      7:       e_sel = tk ? 9 : 7;
      default: e_sel = 9;
    endcase
    e_rld = wr ? (1 << ((opc == 7) ? 7 : rx)) : 0;
    for (int i = 0; i < tr_len; i++) begin
      n_rd += int'(tr[i].mem_rd); n_wr += int'(tr[i].mem_wr); n_a += int'(tr[i].a_ld);
      n_g += int'(tr[i].g_ld); n_f += int'(tr[i].flag_ld); n_dout += int'(tr[i].dout_ld);
      n_rl += (tr[i].reg_ld != 0) ? 1 : 0;
      n_bad += (tr[i].mem_rd && tr[i].mem_wr) ? 1 : 0;
      n_bad += ($countones(tr[i].reg_ld) > 1) ? 1 : 0;
    end
    chk({tag, " cycles"}, tr_len, m_lat(opc, tk) + fw + (mem ? mw : 0));
    chk({tag, " done_sel"}, tr[tr_len-1].sel, e_sel);
    chk({tag, " done_reg_ld"}, tr[tr_len-1].reg_ld, e_rld);
    chk({tag, " done_op"}, tr[tr_len-1].op, (opc == 6) ? 1 : 0);
    chk({tag, " n_mem_rd"}, n_rd, fw + 1 + ((opc == 4) ? mw + 1 : 0));
    chk({tag, " n_mem_wr"}, n_wr, (opc == 5) ? mw + 1 : 0);
    chk({tag, " n_dout_ld"}, n_dout, (opc == 5) ? mw + 1 : 0);
    chk({tag, " n_a_ld"}, n_a, (alu || opc == 7) ? 1 : 0);
    chk({tag, " n_g_ld"}, n_g, (alu || (opc == 7 && tk)) ? 1 : 0);
    chk({tag, " n_flag_ld"}, n_f, alu ? 1 : 0);
    chk({tag, " n_reg_ld"}, n_rl, wr ? 1 : 0);
    chk({tag, " exclusivity"}, n_bad, 0);
  endtask

  vec_t vt[12];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int s;
    vt[0]  = '{16'h1E05, 4'h0, 0, 0, 3, 8'h80, 4'd8};
    vt[1]  = '{16'h4401, 4'h0, 0, 0, 5, 8'h04, 4'd9};
    vt[2]  = '{16'h0403, 4'h0, 0, 0, 3, 8'h04, 4'd3};
    vt[3]  = '{16'h2800, 4'h0, 0, 0, 3, 8'h10, 4'd8};
    vt[4]  = '{16'hDA00, 4'h0, 0, 0, 5, 8'h20, 4'd9};
    vt[5]  = '{16'h6006, 4'h0, 2, 0, 7, 8'h01, 4'd9};
    vt[6]  = '{16'h8605, 4'h0, 0, 1, 7, 8'h08, 4'd10};
    vt[7]  = '{16'hA204, 4'h0, 1, 2, 8, 8'h00, 4'd1};
    vt[8]  = '{16'hEE00, 4'b0100, 0, 0, 5, 8'h80, 4'd9};
    vt[9]  = '{16'hEE00, 4'b0110, 0, 0, 3, 8'h00, 4'd7};
    vt[10] = '{16'hE200, 4'b0001, 0, 0, 5, 8'h80, 4'd9};
    vt[11] = '{16'hE200, 4'b0000, 0, 0, 3, 8'h00, 4'd7};

    rst8_n = 1'b0; run8 = 1'b1;
    bus8.ir = '0; bus8.flags = '0; bus8.mem_ready = 1'b0;
    rst16_n = 1'b0; run16 = 1'b0;
    bus16.ir = '0; bus16.flags = '0; bus16.mem_ready = 1'b0;

    // reset held for two edges with run=1
    @(posedge clk); #1; chk("reset_outs_c1", snap(), 0);
    @(posedge clk); #1; chk("reset_outs_c2", snap(), 0);
    rst8_n = 1'b1;
    #1; chk("idle_outs", snap(), 0);
    @(posedge clk); #1;
    chk("f0_sel", bus8.sel, 7);
    chk("f0_addr_ld", bus8.addr_ld, 1);
    chk("f0_pc_incr", bus8.pc_incr, 1);

    foreach (vt[i]) begin
      run_instr(vt[i].ir, vt[i].fl, vt[i].fw, vt[i].mw, 1'b0);
      chk($sformatf("vec%0d cycles", i), tr_len, vt[i].cyc);
      chk($sformatf("vec%0d reg_ld", i), tr[tr_len-1].reg_ld, vt[i].rld);
      chk($sformatf("vec%0d sel", i), tr[tr_len-1].sel, vt[i].sel);
    end

    // ADD R2,R1 step by step
    run_instr(16'h4401, 4'h0, 0, 0, 1'b0);
    chk("add_t3_sel", tr[2].sel, 2);
    chk("add_t3_a_ld", tr[2].a_ld, 1);
    chk("add_t4_sel", tr[3].sel, 1);
    chk("add_t4_g_flag", {tr[3].g_ld, tr[3].flag_ld, tr[3].add_sub}, 3'b110);
    chk("add_t5", {tr[4].sel, tr[4].reg_ld, tr[4].done}, {4'd9, 8'h04, 1'b1});

    // LD with three wait cycles in S_MW
    run_instr(16'h8605, 4'h0, 0, 3, 1'b0);
    chk("ld_wait_cycles", tr_len, 9);
    s = 0;
    for (int i = 4; i < 8; i++) s += int'(tr[i].mem_rd);
    chk("ld_mw_mem_rd_held", s, 4);
    chk("ld_no_early_reg_ld", tr[7].reg_ld, 0);
    chk("ld_reg_ld", {tr[8].sel, tr[8].reg_ld, tr[8].done}, {4'd10, 8'h08, 1'b1});

    for (int k = 0; k < 40; k++) begin
      logic [15:0] rir;
      logic [3:0]  rfl;
      int rfw, rmw;
      rir = 16'($urandom);
      rfl = 4'($urandom);
      rfw = int'($urandom_range(0, 2));
      rmw = int'($urandom_range(0, 3));
      run_instr(rir, rfl, rfw, rmw, 1'b0);
      check_model(rir, rfl, rfw, rmw, $sformatf("rnd%0d ir=%h", k, rir));
    end

    // run dropped during a store wait: store finishes, then idle
    run_instr(16'hA204, 4'h0, 0, 2, 1'b1);
    chk("st_drop_cycles", tr_len, 7);
    chk("st_drop_done_wr", {tr[tr_len-1].mem_wr, tr[tr_len-1].done}, 2'b11);
    chk("st_drop_idle1", snap(), 0);
    @(posedge clk); #1;
    chk("st_drop_idle2", snap(), 0);
    run8 = 1'b1;
    @(posedge clk); #1;
    chk("restart_f0", {bus8.sel, bus8.addr_ld, bus8.pc_incr}, {4'd7, 2'b11});

    // NREG=16, DATA_W=24: reset during LD memory wait
    run16 = 1'b1;
    #1; chk("w24_reset_outs", {bus16.sel, bus16.reg_ld, bus16.mem_rd, bus16.addr_ld}, 0);
    rst16_n = 1'b1;
    @(posedge clk); #1;
    chk("w24_f0", {bus16.sel, bus16.addr_ld, bus16.pc_incr}, {5'd15, 2'b11});
    bus16.ir = 24'h830002;
    bus16.mem_ready = 1'b1;
    @(posedge clk); #1;
    chk("w24_f1", {bus16.mem_rd, bus16.ir_ld}, 2'b11);
    @(posedge clk); #1;
    chk("w24_t3", {bus16.sel, bus16.addr_ld}, {5'd2, 1'b1});
    bus16.mem_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("w24_mw_rd", {bus16.mem_rd, bus16.reg_ld}, {1'b1, 16'h0000});
    rst16_n = 1'b0;
    @(posedge clk); #1;
    chk("w24_reset_abort", {bus16.sel, bus16.reg_ld, bus16.mem_rd, bus16.done}, 0);
    bus16.mem_ready = 1'b1;
    #1;
    chk("w24_reset_no_ld", {bus16.reg_ld, bus16.mem_rd}, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/cpu_ctrl_fsm_p.md
Name: cpu_ctrl_fsm_p

Overview:
- Parametrised multi-cycle control unit for the enhanced processor datapath; generalised successor to the fixed 16-bit/8-register controller.
- Decodes the IR and drives register-load strobes, bus select, ALU op and memory strobes, with width and register count set by parameters.
- Adds a mem_req/mem_ready wait-state handshake on fetch, LD and ST.
- Adds a signed-LT branch condition using an overflow flag, and clean run/stop semantics: an instruction in progress always completes.

Parameters:
DATA_W, 16, instruction/data width (>=16)
NREG, 8, general registers, power of 2 (>=8); register NREG-1 is PC
REG_AW, $clog2(NREG), register index width (derived, not overridable)
SEL_W, $clog2(NREG+3), bus select width (derived)

Ports:
clk  in  1  clock
reset_n  in  1  synchronous active-low reset
run  in  1  1 = fetch/execute instructions; 0 = stop after current instruction
ir  in  DATA_W  instruction register contents
flags  in  4  {c, v, n, z} from flag register
mem_ready  in  1  memory completed the current read/write this cycle
sel  out  SEL_W  bus select: 0..NREG-1 = register, NREG = IR, NREG+1 = G, NREG+2 = DIN
reg_ld  out  NREG  one-hot register load, active-high
ir_ld, a_ld, g_ld, flag_ld, addr_ld, dout_ld  out  1 each  load strobes, active-high
pc_incr  out  1  increment PC
add_sub  out  1  0 = add, 1 = subtract
op  out  2  ALU op: 00 = add/sub, 01 = AND
mem_rd, mem_wr  out  1 each  memory request, held until mem_ready
done  out  1  one-cycle pulse in the last cycle of every instruction

Behaviour:
- Clock and reset: one clock (clk); reset_n is synchronous and active-low. reset_n=0 at a clk edge forces state S_IDLE and aborts any instruction.
- Idle/reset outputs: in S_IDLE every output is 0 (sel=0, op=00, reg_ld=0).
- Output timing: outputs are combinational from state, ir, flags and mem_ready. Unlisted outputs are 0 in every state; sel and op are never X.
- IR fields: opcode=ir[DATA_W-1:DATA_W-3]; imm=ir[DATA_W-4]; RX=ir[DATA_W-5 -: REG_AW]; RY=ir[REG_AW-1:0]; cond=RX[2:0].
- Opcodes: MV=0, MVT=1, ADD=2, SUB=3, LD=4, ST=5, AND=6, BRN=7. Operand select = NREG if imm, else RY.
- States: S_IDLE, S_F0, S_F1, S_T3, S_T4, S_MW, S_T5. The two fetch states are S_F0/S_F1.
- S_IDLE: -> S_F0 when run=1.
- S_F0: sel=NREG-1, addr_ld=1, pc_incr=1. -> S_F1.
- S_F1: mem_rd=1. When mem_ready: ir_ld=1, -> S_T3. Otherwise stay; wait is unbounded.
- S_T3 (execute 1):
  - MV/MVT: sel=operand (MVT: NREG), reg_ld[RX]=1, done.
  - ADD/SUB/AND: sel=RX, a_ld=1.
  - LD/ST: sel=RY, addr_ld=1.
  - BRN: sel=NREG-1, a_ld=1. Not-taken -> done.
- Branch conditions: 0 always, 1 z, 2 !z, 3 !c, 4 c, 5 !n, 6 n, 7 n^v (signed LT).
- S_T4 (execute 2):
  - ADD/SUB/AND: sel=operand, g_ld=1, flag_ld=1, op=00 (ADD/SUB) or 01 (AND), add_sub=(opcode==SUB).
  - BRN: sel=NREG, g_ld=1, op=00, add_sub=0.
  - LD/ST: -> S_MW. Others -> S_T5.
- S_MW (memory wait):
  - LD: mem_rd=1; on mem_ready -> S_T5.
  - ST: sel=RX, dout_ld=1 (first cycle and every wait cycle), mem_wr=1; on mem_ready -> done.
- S_T5 (execute 3):
  - ADD/SUB/AND: sel=NREG+1, reg_ld[RX]=1, op held as in T4.
  - LD: sel=NREG+2, reg_ld[RX]=1.
  - BRN: sel=NREG+1, reg_ld[NREG-1]=1.
  - All: done.
- After done: -> S_F0 if run=1, else S_IDLE. run=0 mid-instruction does not abort.
- Latency with zero-wait memory (mem_ready=1 on first request cycle): MV 3 cycles, ALU 5, branch taken 5, branch not taken 3, ST 5, LD 6. Each extra wait cycle adds 1.
- mem_rd and mem_wr are never both 1. reg_ld is one-hot or zero.

Decomposition:
- Package cpu_ctrl_pkg holds: opcode, condition and state enumerations; ALU op constants; the sel offset constants for IR, G and DIN (functions of NREG).
- Optional sub-module cpu_branch_cond: combinational cond x flags -> taken.
- Everything else stays in one module.

Test Plan:
1. Reset: reset_n=0 for 2 cycles with run=1 -> all outputs 0; first cycle after release shows addr_ld=1, sel=7, pc_incr=1.
2. Immediate move: NREG=8, ir=0x1E05 (MV imm, RX=7), mem_ready=1 -> reg_ld=0x80, sel=8 in cycle 3; done pulses once.
3. Register ADD: ir=0x4401 (ADD R2,R1) -> T3 sel=2/a_ld; T4 sel=1/g_ld/flag_ld/add_sub=0; T5 sel=9/reg_ld=0x04/done.
4. Load with wait states: LD, mem_ready low for 3 cycles in S_MW -> mem_rd held 4 cycles; reg_ld strobe only after mem_ready; LD total 9 cycles.
5. Branch conditions: BRN cond=7 with flags {c,v,n,z}=0100 -> taken (5 cycles, reg_ld=0x80); flags 0110 -> not taken (done at T3).
6. Run and reset mid-instruction: run dropped in an ST's S_MW -> store completes, then S_IDLE. NREG=16, DATA_W=24: reset_n=0 during LD S_MW -> S_IDLE next edge, mem_rd=0.
